// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the RV32I instruction fetch stage.
package fetch_stage_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Branch targets are forced onto a word boundary; there is no misalignment trap.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush has priority over hold so a squashed slot is never frozen.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_pc_plus4,
    input  logic [31:0] in_inst,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_inst
);

    logic        valid_d, valid_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] pc_plus4_d, pc_plus4_q;
    logic [31:0] inst_d, inst_q;

    // Next-state selection: flush inserts a bubble, hold freezes, otherwise load.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        inst_d     = inst_q;
        if (flush) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            pc_plus4_d = '0;
            inst_d     = NOP_INST;
        end else if (!hold) begin
            valid_d    = 1'b1;
            pc_d       = in_pc;
            pc_plus4_d = in_pc_plus4;
            inst_d     = in_inst;
        end
    end

    // Register update with synchronous reset to an empty (NOP) slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            inst_q     <= NOP_INST;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            inst_q     <= inst_d;
        end
    end

    assign id_valid    = valid_q;
    assign id_pc       = pc_q;
    assign id_pc_plus4 = pc_plus4_q;
    assign id_inst     = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: program counter, imem address, fetch counter and the IF/ID register.
// Priority each edge: reset, redirect (even when stalled), stall, normal advance.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = XLEN_DEFAULT       // only 32 is supported
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [XLEN-1:0] id_inst,
    output logic [31:0]     fetch_count
);

    logic [31:0] pc_d, pc_q;
    logic [31:0] fetch_count_d, fetch_count_q;
    logic [31:0] pc_plus4;

    // Wraps modulo 2^32: FFFF_FFFC advances to 0.
    assign pc_plus4 = pc_q + 32'd4;

    // Next PC and fetch counter; a redirect drops the slot, so the counter holds.
    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        if (redirect_valid) begin
            pc_d = align_word(redirect_pc);
        end else if (!stall) begin
            pc_d          = pc_plus4;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // PC and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .hold        (stall),
        .flush       (redirect_valid),
        .in_pc       (pc_q),
        .in_pc_plus4 (pc_plus4),
        .in_inst     (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_inst     (id_inst)
    );

    assign imem_addr   = pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a reference model predicts every cycle into a scoreboard queue,
// plus directed spot checks for the scenarios of interest.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] idpc;
        logic [31:0] idpc4;
        logic [31:0] inst;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc, id_pc_plus4, id_inst, fetch_count;

    logic        b_stall = 1'b0;
    logic        b_redirect_valid = 1'b0;
    logic [31:0] b_redirect_pc = 32'h0;
    logic [31:0] b_imem_addr, b_imem_rdata;
    logic        b_id_valid;
    logic [31:0] b_id_pc, b_id_pc_plus4, b_id_inst, b_fetch_count;

    int tests_run = 0;
    int tests_failed = 0;

    exp_t        sb_q[$];
    logic [31:0] m_pc, m_idpc, m_idpc4, m_inst, m_cnt;
    logic        m_valid;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    assign imem_rdata   = rom(imem_addr);
    assign b_imem_rdata = rom(b_imem_addr);

    fetch_stage u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_inst        (id_inst),
        .fetch_count    (fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .stall          (b_stall),
        .redirect_valid (b_redirect_valid),
        .redirect_pc    (b_redirect_pc),
        .imem_addr      (b_imem_addr),
        .imem_rdata     (b_imem_rdata),
        .id_valid       (b_id_valid),
        .id_pc          (b_id_pc),
        .id_pc_plus4    (b_id_pc_plus4),
        .id_inst        (b_id_inst),
        .fetch_count    (b_fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, push its prediction, then compare after the edge.
    task automatic step(input logic rst, input logic stl, input logic rv, input logic [31:0] rpc);
        exp_t e;
        @(negedge clk);
        reset          = rst;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_idpc = 32'h0; m_idpc4 = 32'h0; m_inst = NOP; m_cnt = 32'h0;
        end else if (rv) begin
            m_pc = rpc & 32'hFFFF_FFFC; m_valid = 1'b0; m_idpc = 32'h0; m_idpc4 = 32'h0; m_inst = NOP;
        end else if (!stl) begin
            m_valid = 1'b1;
            m_idpc  = m_pc;
            m_idpc4 = m_pc + 32'd4;
            m_inst  = rom(m_pc);
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end
        sb_q.push_back('{m_pc, m_valid, m_idpc, m_idpc4, m_inst, m_cnt});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (!rst) begin
            check("sb_imem_addr",  imem_addr,     e.pc);
            check("sb_id_valid",   {31'b0, id_valid}, {31'b0, e.valid});
            check("sb_id_pc",      id_pc,         e.idpc);
            check("sb_id_pc4",     id_pc_plus4,   e.idpc4);
            check("sb_id_inst",    id_inst,       e.inst);
            check("sb_fetch_cnt",  fetch_count,   e.cnt);
        end
    endtask

    initial begin
        logic [31:0] cnt_snap;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_id_valid",  {31'b0, id_valid}, 32'h0);
        check("rst_id_inst",   id_inst, NOP);
        check("rst_fetch_cnt", fetch_count, 32'h0);
        check("wrap_addr0",    b_imem_addr, 32'hFFFF_FFF8);

        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("first_valid",   {31'b0, id_valid}, 32'h1);
        check("first_inst",    id_inst, 32'h1);
        check("wrap_addr1",    b_imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr2",    b_imem_addr, 32'h0);
        check("wrap_id_pc",    b_id_pc, 32'hFFFF_FFFC);
        check("wrap_id_pc4",   b_id_pc_plus4, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_stall_pc",  id_pc, 32'h8);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            check("stall_id_pc", id_pc, 32'h8);
            check("stall_addr",  imem_addr, 32'hC);
            check("stall_cnt",   fetch_count, 32'd3);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("post_stall_pc",   id_pc, 32'hC);
        check("post_stall_inst", id_inst, 32'h4);

        step(1'b0, 1'b0, 1'b1, 32'h40);
        check("redir_valid", {31'b0, id_valid}, 32'h0);
        check("redir_inst",  id_inst, NOP);
        check("redir_addr",  imem_addr, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("redir_tgt_pc",    id_pc, 32'h40);
        check("redir_tgt_valid", {31'b0, id_valid}, 32'h1);

        cnt_snap = fetch_count;
        step(1'b0, 1'b1, 1'b1, 32'h103);
        check("sr_addr",  imem_addr, 32'h100);
        check("sr_valid", {31'b0, id_valid}, 32'h0);
        check("sr_cnt",   fetch_count, cnt_snap);

        for (int i = 0; i < 30; i++) begin
            logic r;
            r = ($urandom_range(0, 7) == 0);
            step(1'b0, $urandom_range(0, 2) == 0, r, $urandom());
        end

        step(1'b1, 1'b0, 1'b1, 32'h200);
        check("midrst_addr",  imem_addr, 32'h0);
        check("midrst_valid", {31'b0, id_valid}, 32'h0);
        check("midrst_pc",    id_pc, 32'h0);
        check("midrst_pc4",   id_pc_plus4, 32'h0);
        check("midrst_inst",  id_inst, NOP);
        check("midrst_cnt",   fetch_count, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
